// File: rtl/pwm_receiver_decoder.sv
// pwm_receiver_decoder
//
// Purpose: measures the high time of an RC receiver PWM channel in
// microseconds. It turns each accepted pulse into a clamped throttle value
// and flags rejected pulses. It also reports signal loss when no pulse is
// accepted for TIMEOUT_US cycles.
//
// Ports:
//   us_clk       in   1 MHz clock; the only clock
//   resetn       in   synchronous active-low reset
//   pwm_in       in   asynchronous PWM input
//   pwm_val      out  decoded value, forced to 0 while signal_lost is high
//   pwm_valid    out  one-cycle strobe: pwm_val updated
//   pulse_err    out  one-cycle strobe: pulse rejected (too short or too long)
//   signal_lost  out  level: no accepted pulse within TIMEOUT_US
//
// Build option:
//   PWM_RECEIVER_GLITCH_FILTER_EN - when defined, the synchronized level only
//   changes after 3 identical consecutive samples. This adds 2 cycles to both
//   edges, so measured widths are unchanged.
//
// Timing: a falling edge that the first flop samples at edge E0 produces
// pwm_valid or pulse_err in the cycle that starts at edge E0+3. With the
// filter enabled, that cycle starts at edge E0+5.
//
// FSM states (one-hot):
//   state        | meaning
//   WAIT_LOW     | wait for the input to be low (ignore a pulse already in progress)
//   WAIT_RISE    | idle low, wait for a rising edge
//   MEASURE_HIGH | count high time until the falling edge or overflow
module pwm_receiver_decoder #(
    parameter int OUTPUT_BIT_WIDTH = 10,
    parameter int MIN_HIGH_US      = 1000,
    parameter int MAX_HIGH_US      = 2000,
    parameter int MIN_VALID_US     = 500,
    parameter int MAX_VALID_US     = 2500,
    parameter int TIMEOUT_US       = 50000
) (
    input  logic                        us_clk,
    input  logic                        resetn,
    input  logic                        pwm_in,
    output logic [OUTPUT_BIT_WIDTH-1:0] pwm_val,
    output logic                        pwm_valid,
    output logic                        pulse_err,
    output logic                        signal_lost
);

    localparam int TO_W = $clog2(TIMEOUT_US + 1);

    typedef enum logic [2:0] {
        WAIT_LOW     = 3'b001,
        WAIT_RISE    = 3'b010,
        MEASURE_HIGH = 3'b100
    } state_t;

    logic sync_ff1;
    logic sync_ff2;
    logic level;
    logic level_d;
    logic rise;
    logic fall;

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            level_d  <= 1'b0;
        end else begin
            sync_ff1 <= pwm_in;
            sync_ff2 <= sync_ff1;
            level_d  <= level;
        end
    end

`ifdef PWM_RECEIVER_GLITCH_FILTER_EN
    // Number of cycles before every flop that feeds 'level' holds a real
    // post-reset sample.
    localparam int PRIME_CYCLES = 4;

    logic hist1;
    logic hist2;

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
        end else begin
            hist1 <= sync_ff2;
            hist2 <= hist1;
        end
    end

    // level_d doubles as the filter's held output.
    always_comb begin
        level = level_d;
        if (sync_ff2 == hist1 && hist1 == hist2) begin
            level = sync_ff2;
        end
    end
`else
    localparam int PRIME_CYCLES = 2;

    assign level = sync_ff2;
`endif

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    // Reset clears the synchronizer to 0. That reads as "low" and would let a
    // pulse already high at reset be measured, so leaving WAIT_LOW waits until
    // the chain holds real samples.
    logic [2:0] prime_cnt;
    logic       primed;

    assign primed = (prime_cnt == 3'(PRIME_CYCLES));

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            prime_cnt <= 3'd0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 3'd1;
        end
    end

    state_t      state;
    state_t      state_nxt;
    logic [15:0] high_cnt;
    logic [15:0] high_cnt_nxt;
    logic        accept_nxt;
    logic        reject_nxt;

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            state    <= WAIT_LOW;
            high_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            high_cnt <= high_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        high_cnt_nxt = high_cnt;
        accept_nxt   = 1'b0;
        reject_nxt   = 1'b0;
        case (state)
            WAIT_LOW: begin
                if (primed && !level) begin
                    state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    high_cnt_nxt = 16'd1;
                    state_nxt    = MEASURE_HIGH;
                end
            end
            MEASURE_HIGH: begin
                if (high_cnt != 16'hFFFF) begin
                    high_cnt_nxt = high_cnt + 16'd1;
                end
                if (fall) begin
                    if (high_cnt >= 16'(MIN_VALID_US) && high_cnt <= 16'(MAX_VALID_US)) begin
                        accept_nxt = 1'b1;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                    state_nxt = WAIT_RISE;
                end else if (high_cnt >= 16'(MAX_VALID_US + 1)) begin
                    // Stuck high: report once, then wait for a low before re-arming.
                    reject_nxt = 1'b1;
                    state_nxt  = WAIT_LOW;
                end
            end
            default: begin
                state_nxt = WAIT_LOW;
            end
        endcase
    end

    // Clamp in the full 16-bit domain first so that an underflow cannot wrap.
    // Truncation to the output width happens afterwards.
    logic [15:0] clamped;

    always_comb begin
        clamped = 16'd0;
        if (high_cnt >= 16'(MAX_HIGH_US)) begin
            clamped = 16'(MAX_HIGH_US - MIN_HIGH_US);
        end else if (high_cnt > 16'(MIN_HIGH_US)) begin
            clamped = high_cnt - 16'(MIN_HIGH_US);
        end
    end

    // Decision register followed by an output register.
    logic                        accept_q;
    logic                        reject_q;
    logic [OUTPUT_BIT_WIDTH-1:0] dec_q;
    logic [OUTPUT_BIT_WIDTH-1:0] val_hold;

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
            dec_q     <= '0;
            pwm_valid <= 1'b0;
            pulse_err <= 1'b0;
            val_hold  <= '0;
        end else begin
            accept_q  <= accept_nxt;
            reject_q  <= reject_nxt;
            if (accept_nxt) begin
                dec_q <= OUTPUT_BIT_WIDTH'(clamped);
            end
            pwm_valid <= accept_q;
            pulse_err <= reject_q;
            if (accept_q) begin
                val_hold <= dec_q;
            end
        end
    end

    // accept_q is what pwm_valid is about to show, so the timeout counter and
    // signal_lost update on the same edge as pwm_valid. An accepted pulse wins
    // over expiry.
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;

    always_comb begin
        to_cnt_nxt = to_cnt;
        if (accept_q) begin
            to_cnt_nxt = '0;
        end else if (to_cnt != TO_W'(TIMEOUT_US)) begin
            to_cnt_nxt = to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            to_cnt      <= '0;
            signal_lost <= 1'b1;
        end else begin
            to_cnt <= to_cnt_nxt;
            if (accept_q) begin
                signal_lost <= 1'b0;
            end else if (to_cnt_nxt == TO_W'(TIMEOUT_US)) begin
                signal_lost <= 1'b1;
            end
        end
    end

    // Failsafe: report minimum throttle while the signal is lost.
    assign pwm_val = signal_lost ? '0 : val_hold;

endmodule

// File: tb/tb_pwm_receiver_decoder.sv
module tb_pwm_receiver_decoder;

    localparam int W    = 10;
    localparam int MINH = 1000;
    localparam int MAXH = 2000;
    localparam int MINV = 500;
    localparam int MAXV = 2500;
    localparam int TO   = 8000;
`ifdef PWM_RECEIVER_GLITCH_FILTER_EN
    localparam int FD = 2;
`else
    localparam int FD = 0;
`endif

    logic         us_clk = 1'b0;
    logic         resetn = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] pwm_val;
    logic         pwm_valid;
    logic         pulse_err;
    logic         signal_lost;

    always #5 us_clk = ~us_clk;

    pwm_receiver_decoder #(
        .OUTPUT_BIT_WIDTH(W),
        .MIN_HIGH_US(MINH),
        .MAX_HIGH_US(MAXH),
        .MIN_VALID_US(MINV),
        .MAX_VALID_US(MAXV),
        .TIMEOUT_US(TO)
    ) dut (
        .us_clk(us_clk),
        .resetn(resetn),
        .pwm_in(pwm_in),
        .pwm_val(pwm_val),
        .pwm_valid(pwm_valid),
        .pulse_err(pulse_err),
        .signal_lost(signal_lost)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state. Time t counts clock edges since reset release.
    int t;
    bit s0, s1, s2;
    bit f, pf, high;
    int r0;
    int ev_time, ev_kind, ev_val;
    bit have_valid;
    int last_v_time, last_val;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%h expected=%h", tag, t, act, exp);
        end
    endtask

    function automatic int decode(input int n);
        int v;
        if (n <= MINH) v = 0;
        else if (n >= MAXH) v = MAXH - MINH;
        else v = n - MINH;
        return v % (1 << W);
    endfunction

    task automatic model_reset();
        t = 0;
        s0 = 0; s1 = 0; s2 = 0;
        f = 0;
        pf = 1;
        high = 0;
        ev_time = -1;
        ev_kind = 0;
        ev_val = 0;
        have_valid = 0;
        last_v_time = 0;
        last_val = 0;
    endtask

    // Pulse rules: a width of N is measured as N. The strobe for a pulse
    // follows its falling sample by 3 cycles (plus FD when filtered). A pulse
    // longer than MAXV is reported when it is MAXV+1 long.
    task automatic model_edge(input bit s, output bit e_valid, output bit e_err,
                              output bit e_lost, output int e_val);
        int n;
        t++;
        s2 = s1; s1 = s0; s0 = s;
        if (FD > 0) begin
            if (s0 == s1 && s1 == s2) f = s0;
        end else begin
            f = s0;
        end
        if (t >= 1 + FD) begin
            if (f && !pf) begin
                r0 = t;
                high = 1;
                ev_time = t + MAXV + 4;
                ev_kind = 2;
            end else if (!f && pf && high) begin
                high = 0;
                n = t - r0;
                if (n <= MAXV) begin
                    ev_time = t + 3;
                    if (n < MINV) begin
                        ev_kind = 2;
                    end else begin
                        ev_kind = 1;
                        ev_val = decode(n);
                    end
                end
            end
            pf = f;
        end
        e_valid = 0;
        e_err = 0;
        if (ev_time == t) begin
            if (ev_kind == 1) begin
                e_valid = 1;
                last_val = ev_val;
                last_v_time = t;
                have_valid = 1;
            end else begin
                e_err = 1;
            end
            ev_time = -1;
        end
        e_lost = !have_valid || (t - last_v_time >= TO);
        e_val = e_lost ? 0 : last_val;
    endtask

    task automatic step(input bit lvl);
        bit ev, ee, el;
        int vv;
        logic [W-1:0] vexp;
        @(negedge us_clk);
        resetn = 1'b1;
        pwm_in = lvl;
        @(posedge us_clk);
        #1;
        model_edge(lvl, ev, ee, el, vv);
        vexp = vv[W-1:0];
        chk("outputs", {pwm_valid, pulse_err, signal_lost, pwm_val}, {ev, ee, el, vexp});
    endtask

    task automatic step_reset(input bit lvl);
        @(negedge us_clk);
        resetn = 1'b0;
        pwm_in = lvl;
        @(posedge us_clk);
        #1;
        model_reset();
        chk("reset", {pwm_valid, pulse_err, signal_lost, pwm_val}, {1'b0, 1'b0, 1'b1, {W{1'b0}}});
    endtask

    task automatic seg(input bit lvl, input int n);
        repeat (n) step(lvl);
    endtask

    initial begin
        int widths[8];
        widths = '{499, 500, 2500, 2501, 2502, 1000, 2000, 1};

        model_reset();
        repeat (3) step_reset(1'b0);
        seg(0, 20);

        // Regular frames at mid stick.
        repeat (3) begin
            seg(1, 1500);
            seg(0, 3500);
        end

        // Widths below and above the mapping range clamp.
        seg(1, 900);  seg(0, 1000);
        seg(1, 2100); seg(0, 1000);

        // Short pulse, then stuck high, then recovery.
        seg(1, 1500); seg(0, 500);
        seg(1, 300);  seg(0, 500);
        seg(1, 3000); seg(0, 1000);
        seg(1, 1200); seg(0, 500);

        // Glitches.
        seg(1, 1); seg(0, 40);
        seg(1, 2); seg(0, 40);

        // Signal loss and recovery.
        seg(1, 1300); seg(0, TO + 100);
        seg(1, 1700); seg(0, 500);

        // Input already high when reset is released.
        repeat (3) step_reset(1'b1);
        seg(1, 800);  seg(0, 600);
        seg(1, 1200); seg(0, 600);

        // Reset in the middle of a pulse.
        seg(1, 700);
        repeat (2) step_reset(1'b1);
        seg(1, 500);  seg(0, 300);
        seg(1, 1600); seg(0, 500);

        // Acceptance and clamp boundaries.
        foreach (widths[i]) begin
            seg(1, widths[i]);
            seg(0, 300);
        end

        // Random pulse trains.
        for (int i = 0; i < 10; i++) begin
            seg(1, $urandom_range(150, 2800));
            seg(0, $urandom_range(30, 1500));
        end
        seg(0, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_receiver_decoder.md
PWM_RECEIVER_DECODER -- requirements
Module: pwm_receiver_decoder

Interface
REQ-001 Parameter OUTPUT_BIT_WIDTH, default 10: width of decoded value.
REQ-002 Parameter MIN_HIGH_US, default 1000: pulse width that maps to value 0.
REQ-003 Parameter MAX_HIGH_US, default 2000: pulse width that maps to full scale (MAX_HIGH_US-MIN_HIGH_US).
REQ-004 Parameter MIN_VALID_US, default 500: pulses shorter than this are rejected.
REQ-005 Parameter MAX_VALID_US, default 2500: pulses longer than this are rejected.
REQ-006 Parameter TIMEOUT_US, default 50000: cycles without an accepted pulse before signal loss.
REQ-007 us_clk  input  1  1 MHz clock (1 us period); the only clock.
REQ-008 resetn  input  1  reset, synchronous, active-low.
REQ-009 pwm_in  input  1  asynchronous PWM from RC receiver channel.
REQ-010 pwm_val  output  OUTPUT_BIT_WIDTH  decoded, clamped pulse width.
REQ-011 pwm_valid  output  1  one-cycle strobe, pwm_val updated.
REQ-012 pulse_err  output  1  one-cycle strobe, pulse rejected.
REQ-013 signal_lost  output  1  level, no accepted pulse within TIMEOUT_US.

Function
REQ-014 pwm_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized sample and its one-cycle-delayed copy for edge detection.
REQ-015 FSM states SHALL be WAIT_LOW, WAIT_RISE, MEASURE_HIGH, one-hot encoded.
REQ-016 WAIT_LOW -> WAIT_RISE when synchronized input is 0; guarantees a pulse in progress at reset or after abort is never measured.
REQ-017 WAIT_RISE -> MEASURE_HIGH on rising edge; high counter loaded with 1 that cycle.
REQ-018 MEASURE_HIGH: high counter SHALL increment by 1 per cycle, 16 bits, saturating at 16'hFFFF.
REQ-019 MEASURE_HIGH, falling edge, count in [MIN_VALID_US, MAX_VALID_US] -> register pwm_val, pulse pwm_valid, go WAIT_RISE.
REQ-020 MEASURE_HIGH, falling edge, count < MIN_VALID_US -> pulse pulse_err, pwm_val unchanged, go WAIT_RISE.
REQ-021 MEASURE_HIGH, count reaches MAX_VALID_US+1 while high -> pulse pulse_err once, go WAIT_LOW.
REQ-022 Decoded value SHALL be count-MIN_HIGH_US clamped to [0, MAX_HIGH_US-MIN_HIGH_US]; no wrap on underflow; truncation to OUTPUT_BIT_WIDTH only after clamping.
REQ-023 Latency without filter: pwm_valid SHALL be high in the 4th us_clk cycle after the first us_clk edge sampling pwm_in low; a pulse of N us SHALL measure as N.
REQ-024 Timeout counter SHALL increment each cycle, clear on every pwm_valid, saturate at TIMEOUT_US.
REQ-025 signal_lost SHALL set when the timeout counter reaches TIMEOUT_US, clear on the same cycle as the next pwm_valid.
REQ-026 While signal_lost=1, pwm_val SHALL read 0 (failsafe = minimum throttle).
REQ-027 Simultaneous accepted pulse and timeout expiry: pwm_valid wins; counter cleared, signal_lost remains 0.
REQ-028 pwm_valid and pulse_err SHALL never be high in the same cycle.

Reset
REQ-029 On resetn=0 at a us_clk edge: state=WAIT_LOW, synchronizer and edge flops=0, counters=0, pwm_val=0, pwm_valid=0, pulse_err=0, signal_lost=1.
REQ-030 Reset mid-pulse SHALL discard the measurement; first output after reset only from a complete low-high-low pulse.

Configuration
REQ-031 Macro PWM_RECEIVER_GLITCH_FILTER_EN defined: synchronized input SHALL change only after 3 consecutive identical samples; adds exactly 2 cycles to both edges, so measured width and REQ-023 latency +2 hold.
REQ-032 Macro undefined: no filter; a 1-cycle glitch SHALL be treated as a real edge (high glitch -> pulse_err).

Verification
REQ-033 Reset, then 1500 us high / 18500 us low repeated -> pwm_valid once per period, pwm_val=500, signal_lost clears on first pwm_valid.
REQ-034 Pulses 900 us and 2100 us -> pwm_val=0 and 1000 respectively, pwm_valid each, no pulse_err.
REQ-035 Pulse 300 us -> pulse_err one cycle, pwm_val holds prior value; input stuck high 3000 us -> single pulse_err at count 2501, no pwm_valid until after a low.
REQ-036 pwm_in high when resetn released, falls after 800 us, then 1200 us pulse -> first pwm_valid carries 200, partial pulse ignored.
REQ-037 Valid pulses then pwm_in held low 50000 us -> signal_lost=1, pwm_val=0; next 1700 us pulse -> pwm_val=700, signal_lost=0.
REQ-038 With PWM_RECEIVER_GLITCH_FILTER_EN, 1-cycle and 2-cycle high glitches -> no pulse_err, no pwm_valid; without macro, same glitches -> pulse_err each.
